// File: rtl/dmem_access_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size/sign codes,
// FSM state encoding and the access-size helper.
package dmem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Access size in bytes; the sign bit funct3[2] does not affect the size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a 64-bit memory dword and the pipeline:
// load extract with sign/zero extension, and store merge into an old dword.
module dmem_lane_align
    import dmem_access_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata,
    output logic [63:0] merged
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] size_mask;

    assign shamt = {offset, 3'b000};
    assign lane  = dword >> shamt;

    // Load extract: the addressed bytes are shifted down, then extended.
    always_comb begin
        // NOTE: a default on every path keeps this combinational; a missing one infers a latch.
        rdata = lane;
        case (funct3)
            F3_B:    rdata = {{56{lane[7]}}, lane[7:0]};
            F3_BU:   rdata = {56'd0, lane[7:0]};
            F3_H:    rdata = {{48{lane[15]}}, lane[15:0]};
            F3_HU:   rdata = {48'd0, lane[15:0]};
            F3_W:    rdata = {{32{lane[31]}}, lane[31:0]};
            F3_WU:   rdata = {32'd0, lane[31:0]};
            default: rdata = lane;
        endcase
    end

    // Store merge: replace only the bytes covered by the access, keep the rest.
    always_comb begin
        size_mask = '1;
        case (size_bytes(funct3))
            4'd1:    size_mask = 64'h0000_0000_0000_00FF;
            4'd2:    size_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
        merged = (dword & ~(size_mask << shamt)) | ((wdata & size_mask) << shamt);
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage controller for a 64-bit, byte-addressed data memory that only
// writes whole 8-byte lanes. Sub-dword stores are done as read-modify-write.
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              dm_MemRead,
    output logic              dm_MemWrite,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [63:0]       dm_write_data,
    input  logic [63:0]       dm_read_data
);

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic              err_q;
    logic [63:0]       merge_q;

    logic [3:0]        req_size;
    logic              misaligned;
    logic              out_of_range;
    logic              illegal;
    logic              acc_err;
    logic [63:0]       lane_dword;
    logic [63:0]       load_data;
    logic [63:0]       merged_data;
    logic [63:0]       wr_data;

    // Request checks, evaluated on the incoming request at accept time.
    always_comb begin
        req_size     = size_bytes(req_funct3);
        misaligned   = (req_addr[2:0] & 3'(req_size - 4'd1)) != 3'b000;
        // One extra bit so an address near the top of the space cannot wrap.
        out_of_range = ({1'b0, req_addr[ADDR_W-1:3], 3'b000} + (ADDR_W+1)'(8))
                       > (ADDR_W+1)'(MEM_BYTES);
        illegal      = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
        acc_err      = misaligned || out_of_range || illegal;
    end

    // Loads extract from live read data in RD; merges use the captured dword in WR.
    assign lane_dword = (state == S_WR) ? merge_q : dm_read_data;

    dmem_lane_align u_lane_align (
        .dword  (lane_dword),
        .wdata  (wdata_q),
        .offset (addr_q[2:0]),
        .funct3 (f3_q),
        .rdata  (load_data),
        .merged (merged_data)
    );

    assign wr_data = (f3_q[1:0] == 2'b11) ? wdata_q : merged_data;

    // Strobes and handshakes decode from the state register so reset drops them at once.
    assign req_ready     = (state == S_IDLE);
    assign resp_valid    = (state == S_RESP);
    assign resp_err      = (state == S_RESP) && err_q;
    assign dm_MemRead    = (state == S_RD);
    assign dm_MemWrite   = (state == S_WR);
    assign dm_addr       = {addr_q[ADDR_W-1:3], 3'b000};
    assign dm_write_data = (state == S_WR) ? wr_data : 64'd0;

    // Access sequencer: IDLE -> [RD] -> [WR] -> RESP -> IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
            err_q      <= 1'b0;
            merge_q    <= 64'd0;
            resp_rdata <= 64'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= acc_err;
                        if (acc_err)
                            state <= S_RESP;
                        else if (req_we && (req_funct3[1:0] == 2'b11))
                            state <= S_WR;
                        else
                            state <= S_RD;
                    end
                end
                S_RD: begin
                    merge_q <= dm_read_data;
                    if (we_q) begin
                        state <= S_WR;
                    end else begin
                        resp_rdata <= load_data;
                        state      <= S_RESP;
                    end
                end
                S_WR:    state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: the driver queues expected responses
// and expected memory writes; independent monitors pop and compare them.
module tb_dmem_access_unit;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [63:0] dm_addr;
    logic [63:0] dm_write_data;
    logic [63:0] dm_read_data;

    dmem_access_unit #(.MEM_BYTES(128), .ADDR_W(64)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .dm_MemRead    (dm_MemRead),
        .dm_MemWrite   (dm_MemWrite),
        .dm_addr       (dm_addr),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- memory model (128 bytes, little-endian lanes) ----------------
    logic [7:0] mem [0:127];
    logic       preload;

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= (i >= 120) ? 8'(i + 8) : 8'h00;
        end else if (dm_MemWrite) begin
            for (int k = 0; k < 8; k++)
                mem[{dm_addr[6:3], 3'(k)}] <= dm_write_data[8*k +: 8];
        end
    end

    always_comb begin
        dm_read_data = 64'd0;
        for (int k = 0; k < 8; k++)
            dm_read_data[8*k +: 8] = mem[{dm_addr[6:3], 3'(k)}];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
        time         t_acc;
        string       name;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        string       name;
    } wr_t;

    exp_t        sb_q[$];
    wr_t         wr_q[$];
    int          n_cmp;
    int          n_fail;
    int          strobe_cycles;
    logic [63:0] last_load;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Response monitor: pops one expectation per resp_valid pulse.
    always @(negedge CLK) begin
        if (!RST && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_err"},   64'(resp_err), 64'(e.err));
                check({e.name, "_rdata"}, resp_rdata, e.rdata);
                check({e.name, "_lat"},   64'((($time - e.t_acc) - 5) / 10 + 1), 64'(e.lat));
            end
        end
        if (!RST && resp_err)
            check("resp_err_qualified", 64'(resp_valid), 64'd1);
    end

    // Memory-port monitor: writes against the expected-write queue, strobe sanity.
    always @(negedge CLK) begin
        if (!RST && (dm_MemRead || dm_MemWrite))
            strobe_cycles++;
        if (!RST && dm_MemWrite) begin
            check("strobe_exclusive", 64'(dm_MemRead), 64'd0);
            if (wr_q.size() == 0) begin
                check("unexpected_write", 64'(dm_MemWrite), 64'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check({w.name, "_wr_addr"}, dm_addr, w.addr);
                check({w.name, "_wr_data"}, dm_write_data, w.data);
            end
        end
        if (!RST && dm_MemRead)
            check("wdata_zero_in_rd", dm_write_data, 64'd0);
    end

    // ---------------- driver ----------------
    // Drives a request at a falling edge and holds it until accepted; queues expectations.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic exp_err, input logic [63:0] exp_load,
                         input int lat, input logic [63:0] exp_wr, output time t_acc);
        int n;
        @(negedge CLK);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        t_acc = 0;
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 64'(req_ready), 64'd1);
        end else begin
            @(posedge CLK);
            t_acc = $time;
            if (!exp_err && !we)
                last_load = exp_load;
            sb_q.push_back('{exp_err, last_load, lat, t_acc, name});
            if (we && !exp_err)
                wr_q.push_back('{{addr[63:3], 3'b000}, exp_wr, name});
        end
    endtask

    task automatic go_idle();
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_drain_resp"},  64'(sb_q.size()), 64'd0);
        check({name, "_drain_write"}, 64'(wr_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    time t1, t2, t3, t4;
    int  strobe_snap;

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        strobe_cycles = 0;
        last_load     = 64'd0;
        RST           = 1'b1;
        preload       = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready",   64'(req_ready),   64'd1);
        check("rst_resp_valid",  64'(resp_valid),  64'd0);
        check("rst_resp_err",    64'(resp_err),    64'd0);
        check("rst_mem_read",    64'(dm_MemRead),  64'd0);
        check("rst_mem_write",   64'(dm_MemWrite), 64'd0);
        check("rst_dm_addr",     dm_addr,          64'd0);
        check("rst_write_data",  dm_write_data,    64'd0);
        check("rst_resp_rdata",  resp_rdata,       64'd0);
        RST     = 1'b0;
        preload = 1'b0;

        // Stores and loads over dword 0x10.
        issue("sd_10",  1, 3'b011, 64'h10, 64'h1122334455667788, 0, 0, 2, 64'h1122334455667788, t1);
        issue("ld_10a", 0, 3'b011, 64'h10, 0, 0, 64'h1122334455667788, 2, 0, t1);
        issue("sb_13",  1, 3'b000, 64'h13, 64'h55555555555555AA, 0, 0, 3, 64'h11223344AA667788, t1);
        issue("ld_10b", 0, 3'b011, 64'h10, 0, 0, 64'h11223344AA667788, 2, 0, t1);
        issue("lb_13",  0, 3'b000, 64'h13, 0, 0, 64'hFFFFFFFFFFFFFFAA, 2, 0, t1);
        issue("lbu_13", 0, 3'b100, 64'h13, 0, 0, 64'h00000000000000AA, 2, 0, t1);
        issue("sw_14",  1, 3'b010, 64'h14, 64'h12345678DEADBEEF, 0, 0, 3, 64'hDEADBEEFAA667788, t1);
        issue("lw_14",  0, 3'b010, 64'h14, 0, 0, 64'hFFFFFFFFDEADBEEF, 2, 0, t1);
        issue("lwu_14", 0, 3'b110, 64'h14, 0, 0, 64'h00000000DEADBEEF, 2, 0, t1);
        issue("lw_10",  0, 3'b010, 64'h10, 0, 0, 64'hFFFFFFFFAA667788, 2, 0, t1);
        issue("lh_12",  0, 3'b001, 64'h12, 0, 0, 64'hFFFFFFFFFFFFAA66, 2, 0, t1);
        issue("lhu_16", 0, 3'b101, 64'h16, 0, 0, 64'h000000000000DEAD, 2, 0, t1);
        issue("sh_20",  1, 3'b001, 64'h20, 64'hFFFF000000001234, 0, 0, 3, 64'h0000000000001234, t1);
        issue("ld_20",  0, 3'b011, 64'h20, 0, 0, 64'h0000000000001234, 2, 0, t1);
        go_idle();
        drain("basic");

        // Error path: one-cycle response, no memory strobes, resp_rdata held.
        strobe_snap = strobe_cycles;
        issue("lh_11_misal",  0, 3'b001, 64'h11, 0, 1, 0, 1, 0, t1);
        issue("ld_80_range",  0, 3'b011, 64'h80, 0, 1, 0, 1, 0, t1);
        issue("f3_111",       0, 3'b111, 64'h10, 0, 1, 0, 1, 0, t1);
        issue("sbu_illegal",  1, 3'b100, 64'h10, 64'h77, 1, 0, 1, 0, t1);
        issue("sd_14_misal",  1, 3'b011, 64'h14, 64'h77, 1, 0, 1, 0, t1);
        issue("ld_wrap",      0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 0, 1, 0, 1, 0, t1);
        go_idle();
        drain("errors");
        check("err_no_strobes", 64'(strobe_cycles - strobe_snap), 64'd0);

        // Top dword of memory is in range.
        issue("ld_78", 0, 3'b011, 64'h78, 0, 0, 64'h8786858483828180, 2, 0, t1);
        issue("lw_7c", 0, 3'b010, 64'h7C, 0, 0, 64'hFFFFFFFF87868584, 2, 0, t1);

        // Back-to-back with req_valid held: accept spacing is latency + 1 cycles.
        issue("sd_30",  1, 3'b011, 64'h30, 64'hA5A5A5A5A5A5A5A5, 0, 0, 2, 64'hA5A5A5A5A5A5A5A5, t1);
        issue("sd_38",  1, 3'b011, 64'h38, 64'h0123456789ABCDEF, 0, 0, 2, 64'h0123456789ABCDEF, t2);
        check("gap_sd", 64'(t2 - t1), 64'd30);
        issue("sb_30",  1, 3'b000, 64'h30, 64'h01, 0, 0, 3, 64'hA5A5A5A5A5A5A501, t3);
        issue("sb_31",  1, 3'b000, 64'h31, 64'h02, 0, 0, 3, 64'hA5A5A5A5A5A50201, t4);
        check("gap_sb", 64'(t4 - t3), 64'd40);
        issue("ld_30",  0, 3'b011, 64'h30, 0, 0, 64'hA5A5A5A5A5A50201, 2, 0, t1);
        issue("ld_38",  0, 3'b011, 64'h38, 0, 0, 64'h0123456789ABCDEF, 2, 0, t1);
        go_idle();
        drain("b2b");

        // Reset while a byte store sits in RD: nothing may be written.
        issue("sb_rst", 1, 3'b000, 64'h10, 64'h00, 0, 0, 3, 64'hDEADBEEFAA667700, t1);
        @(negedge CLK);
        check("rst_mid_in_rd", 64'(dm_MemRead), 64'd1);
        RST       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_mid_mem_read",  64'(dm_MemRead),  64'd0);
        check("rst_mid_mem_write", 64'(dm_MemWrite), 64'd0);
        check("rst_mid_ready",     64'(req_ready),   64'd1);
        check("rst_mid_resp",      64'(resp_valid),  64'd0);
        check("rst_mid_dm_addr",   dm_addr,          64'd0);
        sb_q.delete();
        wr_q.delete();
        last_load = 64'd0;
        @(negedge CLK);
        RST = 1'b0;
        issue("ld_10_after_rst", 0, 3'b011, 64'h10, 0, 0, 64'hDEADBEEFAA667788, 2, 0, t1);
        go_idle();
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator-side controller that drives the 64-bit, byte-addressed data memory port from the MEM stage of the pipelined processor.
- Supports byte, half, word and doubleword loads (sign- or zero-extended) and stores.
- Sub-doubleword stores are done as read-modify-write, because the memory only writes full 8-byte lanes.
- Holds the pipeline through req_ready while busy.

Parameters:
- MEM_BYTES, 128: data memory size in bytes; an access must satisfy (aligned address + 8) <= MEM_BYTES.
- ADDR_W, 64: address width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from EX/MEM.
- req_ready  out  1  high only in IDLE; request accepted on CLK edge when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 illegal.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load result; held until the next load completes.
- resp_err  out  1  qualified by resp_valid: misaligned, out-of-range or illegal funct3.
- dm_MemRead  out  1  memory read strobe.
- dm_MemWrite  out  1  memory write strobe; the memory writes 8 bytes on this CLK edge.
- dm_addr  out  64  always 8-byte aligned (req_addr with bits [2:0] cleared).
- dm_write_data  out  64  write data.
- dm_read_data  in  64  combinational read data from memory.

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid, resp_err, dm_MemRead, dm_MemWrite = 0; dm_addr, dm_write_data, resp_rdata = 0.
- All registers clear on RST. Strobes are decoded from state, so they drop as soon as RST asserts.
- Reset mid-access aborts it. A store caught in RD is never written. A store caught in WR is not written if RST asserts before the edge.
- States: IDLE, RD, WR, RESP.
- On accept, latch we, funct3, addr, wdata, then check for errors:
  - size misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0);
  - aligned address + 8 > MEM_BYTES;
  - funct3=111;
  - store with funct3[2]=1.
- Error path: IDLE -> RESP with resp_err=1. No strobe is ever asserted.
- Load: IDLE -> RD -> RESP.
  - In RD: dm_MemRead=1, dm_addr=aligned address.
  - On the edge leaving RD, resp_rdata = selected lane (byte offset addr[2:0]), then sign- or zero-extended.
- Store D: IDLE -> WR -> RESP. In WR: dm_MemWrite=1, dm_write_data=wdata.
- Store B/H/W: IDLE -> RD -> WR -> RESP.
  - In RD: capture dm_read_data into the merge register.
  - In WR: write the merge register with bytes [off, off+size-1] replaced by the low bytes of wdata; all other bytes unchanged.
- dm_MemRead and dm_MemWrite are never both high. dm_write_data=0 outside WR.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RD, WR and RESP.
- Latency from the accept edge to resp_valid: error 1 cycle; load 2; store D 2; store B/H/W 3.
- Back-to-back throughput: one request per (latency+1) cycles.
- req_valid while busy is ignored; the requester holds its inputs.
- resp_err=0 whenever resp_valid=0.

Decomposition:
- Shared package/include dmem_access_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - state encodings;
  - function size_bytes(funct3).
- One combinational sub-module dmem_lane_align, containing:
  - load extract/extend (dword, offset, funct3 -> rdata);
  - store merge (old dword, wdata, offset, funct3 -> new dword).
- FSM and registers stay in dmem_access_unit.

Test Plan:
- SD addr 0x10, wdata 0x1122334455667788, then LD 0x10 -> one WR cycle writing dm_addr 0x10; load resp_valid 2 cycles after accept, resp_rdata 0x1122334455667788, resp_err=0.
- SB addr 0x13, wdata 0xAA over the above dword, then LD 0x10 -> RD, then WR with dm_write_data 0x11223344AA667788. A following LB 0x13 returns 0xFFFFFFFFFFFFFFAA; LBU 0x13 returns 0xAA.
- SW addr 0x14, wdata 0xDEADBEEF, then LW/LWU 0x14 -> 0xFFFFFFFFDEADBEEF and 0x00000000DEADBEEF; bytes 0x10-0x13 unchanged.
- LH 0x11 (misaligned), LD 0x78 (0x78+8=128 ok) and LD 0x80 (out of range, MEM_BYTES=128):
  - LH 0x11 -> resp_err=1 one cycle after accept, no strobes;
  - LD 0x78 -> succeeds;
  - LD 0x80 -> resp_err=1.
- RST asserted while a SB is in RD -> strobes drop immediately, state IDLE, req_ready=1, memory contents unchanged.
- req_valid held high across a store: the second request is accepted only on the edge after RESP, with ready=0 through RD/WR/RESP.
